sram_port_arbiter: RTL and testbench

- Sequences the single shared 16-bit SRAM of the ThinPad CPU between two requesters: instruction fetch (IF stage) and data load/store (MEM stage).
- Data accesses win conflicts; the fetch side is stalled until its turn.
- Generates SRAM control strobes with programmable wait states.
- The external data bus is split into din, dout and drive_en; no internal tristate.

---
 rtl/sram_port_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 16-bit asynchronous SRAM between the
// instruction-fetch port and the data load/store port of the ThinPad CPU.
// Data accesses win conflicts; the fetch port is stalled until its turn.
// Strobes are Moore outputs registered from the next state, so they change
// cleanly on clock edges and drop immediately on asynchronous reset.
// Optional build macro: ARB_CONFLICT_CNT_EN enables the saturating conflict
// counter on conflict_cnt; without it the port is tied to zero.
module sram_port_arbiter #(
  parameter int READ_WAIT   = 1,
  parameter int WRITE_PULSE = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [15:0]        if_addr,
  output logic [15:0]        if_data,
  output logic               if_ready,
  output logic               stall_if,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [15:0]        mem_addr,
  input  logic [15:0]        mem_wdata,
  output logic [15:0]        mem_rdata,
  output logic               mem_ready,
  output logic               stall_mem,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_din,
  output logic [15:0]        sram_dout,
  output logic               sram_drive_en,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [15:0]        conflict_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Last value of the wait counter in the multi-cycle states.
  localparam logic [2:0] RD_LAST = 3'(READ_WAIT);
  localparam logic [2:0] WP_LAST = 3'(WRITE_PULSE - 1);

  state_t             state_r, state_s;
  logic [2:0]         cnt_r, cnt_s;
  logic               owner_fetch_r, owner_fetch_s;

  logic [SRAM_AW-1:0] addr_r, addr_s;
  logic [15:0]        dout_r, dout_s;
  logic [15:0]        if_data_r, if_data_s;
  logic [15:0]        mem_rdata_r, mem_rdata_s;
  logic               ce_n_r, ce_n_s;
  logic               oe_n_r, oe_n_s;
  logic               we_n_r, we_n_s;
  logic               drive_en_r, drive_en_s;
  logic               if_ready_r, if_ready_s;
  logic               mem_ready_r, mem_ready_s;

  // FSM state, wait counter and access owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      cnt_r         <= 3'd0;
      owner_fetch_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      owner_fetch_r <= owner_fetch_s;
    end
  end

  // Next-state logic: arbitration in IDLE, latching of the access, read capture.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    owner_fetch_s = owner_fetch_r;
    addr_s        = addr_r;
    dout_s        = dout_r;
    if_data_s     = if_data_r;
    mem_rdata_s   = mem_rdata_r;
    case (state_r)
      IDLE: begin
        cnt_s = 3'd0;
        // A write wins even when a read is requested together with it.
        if (mem_wr) begin
          state_s       = WR_SETUP;
          owner_fetch_s = 1'b0;
          addr_s        = SRAM_AW'(mem_addr);
          dout_s        = mem_wdata;
        end else if (mem_rd) begin
          state_s       = RD;
          owner_fetch_s = 1'b0;
          addr_s        = SRAM_AW'(mem_addr);
        end else if (if_req) begin
          state_s       = RD;
          owner_fetch_s = 1'b1;
          addr_s        = SRAM_AW'(if_addr);
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        if (cnt_r == RD_LAST) begin
          state_s = DONE;
          cnt_s   = 3'd0;
          if (owner_fetch_r) begin
            if_data_s = sram_din;
          end else begin
            mem_rdata_s = sram_din;
          end
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end
      WR_SETUP: begin
        state_s = WR_PULSE;
        cnt_s   = 3'd0;
      end
      WR_PULSE: begin
        if (cnt_r == WP_LAST) begin
          state_s = WR_HOLD;
          cnt_s   = 3'd0;
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end
      WR_HOLD: begin
        state_s = DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // Moore strobe decode from the state about to be entered.
  always_comb begin
    ce_n_s      = 1'b1;
    oe_n_s      = 1'b1;
    we_n_s      = 1'b1;
    drive_en_s  = 1'b0;
    if_ready_s  = 1'b0;
    mem_ready_s = 1'b0;
    case (state_s)
      IDLE: begin
        ce_n_s = 1'b1;
      end
      RD: begin
        ce_n_s = 1'b0;
        oe_n_s = 1'b0;
      end
      WR_SETUP: begin
        ce_n_s     = 1'b0;
        drive_en_s = 1'b1;
      end
      WR_PULSE: begin
        ce_n_s     = 1'b0;
        we_n_s     = 1'b0;
        drive_en_s = 1'b1;
      end
      WR_HOLD: begin
        ce_n_s     = 1'b0;
        drive_en_s = 1'b1;
      end
      DONE: begin
        if (owner_fetch_s) begin
          if_ready_s = 1'b1;
        end else begin
          mem_ready_s = 1'b1;
        end
      end
      default: begin
        ce_n_s = 1'b1;
      end
    endcase
  end

  // Registered outputs; reset drops strobes and bus drive without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r      <= '0;
      dout_r      <= 16'h0000;
      if_data_r   <= 16'h0800;
      mem_rdata_r <= 16'h0000;
      ce_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      drive_en_r  <= 1'b0;
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
    end else begin
      addr_r      <= addr_s;
      dout_r      <= dout_s;
      if_data_r   <= if_data_s;
      mem_rdata_r <= mem_rdata_s;
      ce_n_r      <= ce_n_s;
      oe_n_r      <= oe_n_s;
      we_n_r      <= we_n_s;
      drive_en_r  <= drive_en_s;
      if_ready_r  <= if_ready_s;
      mem_ready_r <= mem_ready_s;
    end
  end

  assign sram_addr     = addr_r;
  assign sram_dout     = dout_r;
  assign sram_drive_en = drive_en_r;
  assign sram_ce_n     = ce_n_r;
  assign sram_oe_n     = oe_n_r;
  assign sram_we_n     = we_n_r;
  assign if_data       = if_data_r;
  assign if_ready      = if_ready_r;
  assign mem_rdata     = mem_rdata_r;
  assign mem_ready     = mem_ready_r;

  // Stalls are combinational so the pipeline freezes in the request cycle.
  assign stall_if  = if_req & ~if_ready_r;
  assign stall_mem = (mem_rd | mem_wr) & ~mem_ready_r;

`ifdef ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_r;

  // Count IDLE edges where both ports compete; saturate, clear only on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_r <= 16'h0000;
    end else if ((state_r == IDLE) && if_req && (mem_rd | mem_wr) &&
                 (conflict_cnt_r != 16'hFFFF)) begin
      conflict_cnt_r <= conflict_cnt_r + 16'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_r;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter (READ_WAIT=1, WRITE_PULSE=1).
// Per-cycle vector table, hand sequences for reset-abort and back-to-back
// fetches, then random transactions against a transaction-level model.
module tb_sram_port_arbiter;

  localparam int RW = 1;
  localparam int WP = 1;
`ifdef ARB_CONFLICT_CNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0000;
  logic [15:0] if_data;
  logic        if_ready, stall_if;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [15:0] mem_wdata = 16'h0000;
  logic [15:0] mem_rdata;
  logic        mem_ready, stall_mem;
  logic [17:0] sram_addr;
  logic [15:0] sram_din, sram_dout;
  logic        sram_drive_en, sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] conflict_cnt;

  sram_port_arbiter #(.READ_WAIT(RW), .WRITE_PULSE(WP), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
    .if_ready(if_ready), .stall_if(stall_if),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stall_mem(stall_mem),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .sram_drive_en(sram_drive_en), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // SRAM device model (256 words, low address byte); writes while ce_n/we_n low.
  logic [15:0] sram_mem [256];
  assign sram_din = sram_mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_drive_en) sram_mem[sram_addr[7:0]] <= sram_dout;
  end

  // Reference memory contents as seen by completed transactions.
  logic [15:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  req;     // {if_req, mem_rd, mem_wr}
    logic [15:0] ia, ma, wd;
    logic [3:0]  strb;    // {ce_n, oe_n, we_n, drive_en}
    logic [3:0]  flg;     // {if_ready, mem_ready, stall_if, stall_mem}
    logic [15:0] addr, dout, ifd, mrd;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] req, input logic [15:0] ia, ma, wd,
                              input logic [3:0] strb, flg,
                              input logic [15:0] addr, dout, ifd, mrd);
    vec_t v;
    v.req = req; v.ia = ia; v.ma = ma; v.wd = wd;
    v.strb = strb; v.flg = flg;
    v.addr = addr; v.dout = dout; v.ifd = ifd; v.mrd = mrd;
    return v;
  endfunction

  localparam logic [3:0] S_RD  = 4'b0010;
  localparam logic [3:0] S_ID  = 4'b1110;
  localparam logic [3:0] S_WS  = 4'b0111;
  localparam logic [3:0] S_WP  = 4'b0101;

  vec_t tbl [22];

  initial begin
    logic [15:0] ia, ma, wd;
    logic        ifq, has_mem, is_wr, exp_ir, exp_mr;
    int          kind, t_m, t_f, last, exp_cc;
    int          pulses [$];

    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 16'h3C00 ^ (16'(i) * 16'h0101);
    end
    sram_mem[8'h04] = 16'h4907;
    sram_mem[8'h08] = 16'h0810;
    sram_mem[8'h20] = 16'h00C8;
    for (int i = 0; i < 256; i++) ref_mem[i] = sram_mem[i];

    // Fetch only
    tbl[0]  = mk(3'b100, 16'h0004, 16'h0000, 16'h0000, S_RD, 4'b0010, 16'h0004, 16'h0000, 16'h0800, 16'h0000);
    tbl[1]  = mk(3'b100, 16'h0004, 16'h0000, 16'h0000, S_RD, 4'b0010, 16'h0004, 16'h0000, 16'h0800, 16'h0000);
    tbl[2]  = mk(3'b100, 16'h0004, 16'h0000, 16'h0000, S_ID, 4'b1000, 16'h0004, 16'h0000, 16'h4907, 16'h0000);
    tbl[3]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, S_ID, 4'b0000, 16'h0004, 16'h0000, 16'h4907, 16'h0000);
    // Write
    tbl[4]  = mk(3'b001, 16'h0000, 16'hCF00, 16'hCF00, S_WS, 4'b0001, 16'hCF00, 16'hCF00, 16'h4907, 16'h0000);
    tbl[5]  = mk(3'b001, 16'h0000, 16'hCF00, 16'hCF00, S_WP, 4'b0001, 16'hCF00, 16'hCF00, 16'h4907, 16'h0000);
    tbl[6]  = mk(3'b001, 16'h0000, 16'hCF00, 16'hCF00, S_WS, 4'b0001, 16'hCF00, 16'hCF00, 16'h4907, 16'h0000);
    tbl[7]  = mk(3'b001, 16'h0000, 16'hCF00, 16'hCF00, S_ID, 4'b0100, 16'hCF00, 16'hCF00, 16'h4907, 16'h0000);
    tbl[8]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, S_ID, 4'b0000, 16'hCF00, 16'hCF00, 16'h4907, 16'h0000);
    // Read and write together: write only
    tbl[9]  = mk(3'b011, 16'h0000, 16'h0040, 16'h1234, S_WS, 4'b0001, 16'h0040, 16'h1234, 16'h4907, 16'h0000);
    tbl[10] = mk(3'b011, 16'h0000, 16'h0040, 16'h1234, S_WP, 4'b0001, 16'h0040, 16'h1234, 16'h4907, 16'h0000);
    tbl[11] = mk(3'b011, 16'h0000, 16'h0040, 16'h1234, S_WS, 4'b0001, 16'h0040, 16'h1234, 16'h4907, 16'h0000);
    tbl[12] = mk(3'b011, 16'h0000, 16'h0040, 16'h1234, S_ID, 4'b0100, 16'h0040, 16'h1234, 16'h4907, 16'h0000);
    tbl[13] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, S_ID, 4'b0000, 16'h0040, 16'h1234, 16'h4907, 16'h0000);
    // Conflict: data read first, then fetch
    tbl[14] = mk(3'b110, 16'h0008, 16'h0020, 16'h0000, S_RD, 4'b0011, 16'h0020, 16'h1234, 16'h4907, 16'h0000);
    tbl[15] = mk(3'b110, 16'h0008, 16'h0020, 16'h0000, S_RD, 4'b0011, 16'h0020, 16'h1234, 16'h4907, 16'h0000);
    tbl[16] = mk(3'b110, 16'h0008, 16'h0020, 16'h0000, S_ID, 4'b0110, 16'h0020, 16'h1234, 16'h4907, 16'h00C8);
    tbl[17] = mk(3'b100, 16'h0008, 16'h0000, 16'h0000, S_ID, 4'b0010, 16'h0020, 16'h1234, 16'h4907, 16'h00C8);
    tbl[18] = mk(3'b100, 16'h0008, 16'h0000, 16'h0000, S_RD, 4'b0010, 16'h0008, 16'h1234, 16'h4907, 16'h00C8);
    tbl[19] = mk(3'b100, 16'h0008, 16'h0000, 16'h0000, S_RD, 4'b0010, 16'h0008, 16'h1234, 16'h4907, 16'h00C8);
    tbl[20] = mk(3'b100, 16'h0008, 16'h0000, 16'h0000, S_ID, 4'b1000, 16'h0008, 16'h1234, 16'h0810, 16'h00C8);
    tbl[21] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, S_ID, 4'b0000, 16'h0008, 16'h1234, 16'h0810, 16'h00C8);

    // Reset state
    #12;
    chk("rst_strobes", 0, {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_drive_en}, {28'd0, 4'b1110});
    chk("rst_ready", 0, {30'd0, if_ready, mem_ready}, 32'd0);
    chk("rst_if_data", 0, {16'd0, if_data}, {16'd0, 16'h0800});
    chk("rst_mem_rdata", 0, {16'd0, mem_rdata}, 32'd0);
    chk("rst_addr_dout", 0, {14'd0, sram_addr}, 32'd0);
    chk("rst_dout", 0, {16'd0, sram_dout}, 32'd0);
    chk("rst_conflict", 0, {16'd0, conflict_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven per-cycle vectors
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      {if_req, mem_rd, mem_wr} = tbl[i].req;
      if_addr = tbl[i].ia; mem_addr = tbl[i].ma; mem_wdata = tbl[i].wd;
      @(posedge clk); #1;
      chk("tbl_strobes", i, {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_drive_en}, {28'd0, tbl[i].strb});
      chk("tbl_flags", i, {28'd0, if_ready, mem_ready, stall_if, stall_mem}, {28'd0, tbl[i].flg});
      chk("tbl_sram_addr", i, {14'd0, sram_addr}, {16'd0, tbl[i].addr});
      chk("tbl_sram_dout", i, {16'd0, sram_dout}, {16'd0, tbl[i].dout});
      chk("tbl_if_data", i, {16'd0, if_data}, {16'd0, tbl[i].ifd});
      chk("tbl_mem_rdata", i, {16'd0, mem_rdata}, {16'd0, tbl[i].mrd});
    end
    ref_mem[8'h00] = 16'hCF00;
    ref_mem[8'h40] = 16'h1234;
    chk("tbl_conflict_cnt", 0, {16'd0, conflict_cnt}, CC_EN ? 32'd1 : 32'd0);

    // Reset during WR_PULSE aborts the write
    @(negedge clk);
    mem_wr = 1'b1; mem_addr = 16'h0050; mem_wdata = 16'hBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_pulse", 0, {31'd0, sram_we_n}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_strobes", 0, {29'd0, sram_ce_n, sram_we_n, sram_drive_en}, {29'd0, 3'b110});
    chk("abort_if_data", 0, {16'd0, if_data}, {16'd0, 16'h0800});
    chk("abort_conflict", 0, {16'd0, conflict_cnt}, 32'd0);
    @(negedge clk);
    mem_wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      chk("abort_no_ready", n, {30'd0, if_ready, mem_ready}, 32'd0);
    end

    // Held fetch request: back-to-back accesses every 4 cycles
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0008;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (if_ready) begin
        pulses.push_back(n);
        chk("held_if_data", n, {16'd0, if_data}, {16'd0, 16'h0810});
        if (pulses.size() == 3) begin
          if_req = 1'b0;
          break;
        end
      end
    end
    chk("held_pulse_count", 0, pulses.size(), 32'd3);
    if (pulses.size() == 3) begin
      chk("held_first", 0, pulses[0], RW + 2);
      chk("held_gap1", 0, pulses[1] - pulses[0], 32'd4);
      chk("held_gap2", 0, pulses[2] - pulses[1], 32'd4);
    end
    @(posedge clk);

    // Random transactions vs. transaction-level model
    exp_cc = 0;
    for (int it = 0; it < 40; it++) begin
      ifq  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);   // 0 none, 1 read, 2 write, 3 read+write
      if (!ifq && kind == 0) ifq = 1'b1;
      ia = 16'($urandom); ma = 16'($urandom); wd = 16'($urandom);
      has_mem = (kind != 0);
      is_wr   = (kind >= 2);
      t_m = has_mem ? (is_wr ? WP + 3 : RW + 2) : 0;
      t_f = ifq ? (has_mem ? t_m + 1 + RW + 2 : RW + 2) : 0;
      last = (t_m > t_f) ? t_m : t_f;
      if (ifq && has_mem) exp_cc++;
      @(negedge clk);
      if_req = ifq; if_addr = ia;
      mem_rd = (kind == 1 || kind == 3);
      mem_wr = is_wr;
      mem_addr = ma; mem_wdata = wd;
      for (int n = 1; n <= last; n++) begin
        @(posedge clk); #1;
        exp_ir = ifq && (n == t_f);
        exp_mr = has_mem && (n == t_m);
        chk("rnd_if_ready", it, {31'd0, if_ready}, {31'd0, exp_ir});
        chk("rnd_mem_ready", it, {31'd0, mem_ready}, {31'd0, exp_mr});
        chk("rnd_stalls", it, {30'd0, stall_if, stall_mem},
            {30'd0, if_req & ~exp_ir, (mem_rd | mem_wr) & ~exp_mr});
        if (exp_mr) begin
          if (is_wr) ref_mem[ma[7:0]] = wd;
          else chk("rnd_mem_rdata", it, {16'd0, mem_rdata}, {16'd0, ref_mem[ma[7:0]]});
          mem_rd = 1'b0; mem_wr = 1'b0;
        end
        if (exp_ir) begin
          chk("rnd_if_data", it, {16'd0, if_data}, {16'd0, ref_mem[ia[7:0]]});
          if_req = 1'b0;
        end
      end
      @(posedge clk);
    end
    #1;
    chk("rnd_conflict_cnt", 0, {16'd0, conflict_cnt}, CC_EN ? exp_cc : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
